simon_panel: RTL and testbench
==============================

SIMON_PANEL -- requirements
Module: simon_panel

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 3: consecutive cycles a synchronized button must differ from its debounced value before that value changes.
REQ-002 SHALL have parameter BLINK_HALF, default 15: cycles per half-period of the game-over blink (2 Hz at 60 Hz).
REQ-003 SHALL have port clk, input, 1 bit: single clock (60 Hz); all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port btn, input, 4 bits: raw, asynchronous player buttons, bit i = colour i.
REQ-006 SHALL have port simonTurn, input, 1 bit: game core is playing its sequence.
REQ-007 SHALL have port simonNum, input, 2 bits: colour the core is showing.
REQ-008 SHALL have port simonPressed, input, 1 bit: the core's colour is lit.
REQ-009 SHALL have port gameOver, input, 1 bit: game ended.
REQ-010 SHALL have port playerNum, output, 2 bits: encoded colour of the last accepted press.
REQ-011 SHALL have port playerPressed, output, 1 bit: one-cycle strobe per accepted press.
REQ-012 SHALL have port led, output, 4 bits: colour lamps, bit i = colour i.

Function
REQ-013 SHALL pass each btn bit through a two-flop synchronizer before any other use.
REQ-014 SHALL debounce each bit with its own counter; debounced bit takes the synchronized value after DEB_CYCLES consecutive differing cycles; any agreeing cycle clears the counter.
REQ-015 SHALL implement press FSM states IDLE (armed), HELD (wait for release), LOCK (wait for release, no press).
REQ-016 In IDLE, when the debounced vector changes from all-zero to one-hot while simonTurn=0 and gameOver=0, SHALL load playerNum with the encoded index, pulse playerPressed for exactly one cycle, and enter HELD.
REQ-017 In IDLE, a transition from all-zero to a vector with two or more bits set SHALL produce no strobe, leave playerNum unchanged, and enter LOCK.
REQ-018 In IDLE, a press while simonTurn=1 or gameOver=1 SHALL be ignored and enter LOCK.
REQ-019 HELD and LOCK SHALL return to IDLE only after the debounced vector is all-zero; additional buttons pressed while in either state SHALL be ignored.
REQ-020 Latency: a clean raw press held from before rising edge 0 SHALL raise playerPressed during the cycle following edge 2+DEB_CYCLES+1 (edge 6 at default).
REQ-021 playerNum SHALL hold its value between accepted presses.
REQ-022 led priority, highest first: gameOver -> blink pattern (REQ-023); simonTurn=1 -> one-hot(simonNum) when simonPressed=1, else 4'b0000; player turn -> one-hot(playerNum) while in HELD, else 4'b0000.
REQ-023 Blink counter SHALL run only while gameOver=1, toggling a phase bit every BLINK_HALF cycles; phase 1 -> led=4'b1111, phase 0 -> 4'b0000; phase starts at 1 and the counter clears when gameOver falls.
REQ-024 simonTurn rising while in HELD SHALL not change state; led follows simonTurn priority immediately.

Reset
REQ-025 On reset: synchronizers, debounced vector and counters = 0; FSM = LOCK; playerNum=2'b00; playerPressed=0; led=4'b0000; blink counter=0, phase=1.
REQ-026 A button held through reset release SHALL not generate a strobe until released and re-pressed.

Configuration
REQ-027 Macro SIMON_PANEL_BLINK_EN: defined -> REQ-023 blink behaviour; undefined -> blink logic absent and led=4'b1111 steadily while gameOver=1.

Verification
REQ-028 Reset, btn=0, simonTurn=0: btn[2] high 10 cycles -> one playerPressed pulse at edge 6 after the press, playerNum=2'b10, led=4'b0100 while held, 4'b0000 after release debounces.
REQ-029 btn[1] glitch high for 2 cycles -> no strobe, playerNum unchanged.
REQ-030 btn[0] and btn[3] pressed in the same cycle -> no strobe; release both, press btn[3] -> strobe, playerNum=2'b11.
REQ-031 simonTurn=1, simonNum=2'b01, simonPressed toggling every 30 cycles -> led alternates 4'b0010/4'b0000; btn[0] pressed meanwhile -> no strobe, even after simonTurn falls while still held.
REQ-032 gameOver=1 with SIMON_PANEL_BLINK_EN defined -> led 4'b1111 for 15 cycles, 4'b0000 for 15, repeating; macro undefined -> steady 4'b1111.
REQ-033 Assert reset during HELD with btn[2] held -> outputs at reset values; deassert with btn[2] still held -> no strobe until release and re-press.

Source files
------------

// File: rtl/simon_panel.sv
// Button front end for a Simon game: synchronizes and debounces four buttons, turns presses
// into one-cycle strobes, and drives the colour lamps. Define SIMON_PANEL_BLINK_EN to blink the lamps at game over.
module simon_panel #(
    parameter int DEB_CYCLES = 3,
    parameter int BLINK_HALF = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic       simonTurn,
    input  logic [1:0] simonNum,
    input  logic       simonPressed,
    input  logic       gameOver,
    output logic [1:0] playerNum,
    output logic       playerPressed,
    output logic [3:0] led
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, HELD, LOCK} pressState_t;

    pressState_t   state, stateNext;
    logic [3:0]    sync1, sync2, deb;
    logic [CW-1:0] debCnt [4];
    logic [1:0]    settle;
    logic          pressStrobe;
    logic          debOneHot;
    logic [1:0]    debIndex;

    // Two-flop synchronizer, then per-bit debounce counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int i = 0; i < 4; i++) debCnt[i] <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (debCnt[i] == CW'(DEB_CYCLES)) begin
                        deb[i]    <= sync2[i];
                        debCnt[i] <= '0;
                    end else begin
                        debCnt[i] <= debCnt[i] + 1'b1;
                    end
                end else begin
                    debCnt[i] <= '0;
                end
            end
        end
    end

    // Holds LOCK until the synchronizer has seen real button values, so a button held
    // through reset release is treated as already pressed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) settle <= '0;
        else if (settle != 2'd2) settle <= settle + 2'd1;
    end

    assign debOneHot = (deb != 4'b0000) && ((deb & (deb - 4'b0001)) == 4'b0000);

    always_comb begin
        debIndex = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (deb[i]) debIndex = 2'(i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= LOCK;
            playerNum     <= 2'b00;
            playerPressed <= 1'b0;
        end else begin
            state         <= stateNext;
            playerPressed <= pressStrobe;
            if (pressStrobe) playerNum <= debIndex;
        end
    end

    always_comb begin
        stateNext   = state;
        pressStrobe = 1'b0;
        case (state)
            IDLE: begin
                if (deb != 4'b0000) begin
                    if (simonTurn || gameOver || !debOneHot) begin
                        stateNext = LOCK;
                    end else begin
                        stateNext   = HELD;
                        pressStrobe = 1'b1;
                    end
                end
            end
            HELD: if (deb == 4'b0000) stateNext = IDLE;
            LOCK: begin
                if (deb == 4'b0000 && sync1 == 4'b0000 && sync2 == 4'b0000 && settle == 2'd2)
                    stateNext = IDLE;
            end
            default: stateNext = LOCK;
        endcase
    end

`ifdef SIMON_PANEL_BLINK_EN
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [BW-1:0] blinkCnt;
    logic          blinkPhase;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blinkCnt   <= '0;
            blinkPhase <= 1'b1;
        end else if (gameOver) begin
            if (blinkCnt == BW'(BLINK_HALF - 1)) begin
                blinkCnt   <= '0;
                blinkPhase <= ~blinkPhase;
            end else begin
                blinkCnt <= blinkCnt + 1'b1;
            end
        end else begin
            blinkCnt   <= '0;
            blinkPhase <= 1'b1;
        end
    end

    wire [3:0] overLed = blinkPhase ? 4'b1111 : 4'b0000;
`else
    wire [3:0] overLed = 4'b1111;
`endif

    always_comb begin
        led = 4'b0000;
        if (gameOver) begin
            led = overLed;
        end else if (simonTurn) begin
            if (simonPressed) led = 4'b0001 << simonNum;
        end else if (state == HELD) begin
            led = 4'b0001 << playerNum;
        end
    end
endmodule

// File: tb/tb_simon_panel.sv
// Directed bench for simon_panel: press latency, debounce, multi-press lockout, Simon turn,
// reset while held and game-over lamps.
module tb_simon_panel;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn;
    logic       simonTurn;
    logic [1:0] simonNum;
    logic       simonPressed;
    logic       gameOver;
    logic [1:0] playerNum;
    logic       playerPressed;
    logic [3:0] led;

    int passCnt = 0;
    int totalCnt = 0;
    int strobeCnt = 0;

    simon_panel dut (
        .clk          (clk),
        .reset        (reset),
        .btn          (btn),
        .simonTurn    (simonTurn),
        .simonNum     (simonNum),
        .simonPressed (simonPressed),
        .gameOver     (gameOver),
        .playerNum    (playerNum),
        .playerPressed(playerPressed),
        .led          (led)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, sampling 1 time unit after each and counting strobes.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (playerPressed) strobeCnt++;
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        totalCnt++;
        assert (obs == exp) passCnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b1; btn = 4'b0000; simonTurn = 1'b0; simonNum = 2'b00;
        simonPressed = 1'b0; gameOver = 1'b0;
        step(3);
        check("rst_led", led, 4'b0000);
        check("rst_num", {2'b00, playerNum}, 4'b0000);
        check("rst_strobe", {3'b000, playerPressed}, 4'b0000);
        reset = 1'b0;
        step(5);

        // Clean press of colour 2: strobe exactly after edge 6.
        btn = 4'b0100; strobeCnt = 0;
        step(6);
        check("lat_before", {3'b000, playerPressed}, 4'b0000);
        step(1);
        check("lat_strobe", {3'b000, playerPressed}, 4'b0001);
        check("press2_num", {2'b00, playerNum}, 4'b0010);
        check("press2_led", led, 4'b0100);
        step(1);
        check("strobe_width", {3'b000, playerPressed}, 4'b0000);
        step(2);
        btn = 4'b0000;
        step(8);
        check("release_led", led, 4'b0000);
        check_int("press2_count", strobeCnt, 1);

        // Two-cycle glitch on colour 1.
        strobeCnt = 0;
        btn = 4'b0010; step(2); btn = 4'b0000;
        step(10);
        check_int("glitch_count", strobeCnt, 0);
        check("glitch_num", {2'b00, playerNum}, 4'b0010);

        // Two buttons at once, then colour 3 alone.
        btn = 4'b1001; step(10);
        check_int("multi_count", strobeCnt, 0);
        check("multi_led", led, 4'b0000);
        check("multi_num", {2'b00, playerNum}, 4'b0010);
        btn = 4'b0000; step(10);
        btn = 4'b1000; step(7);
        check("press3_strobe", {3'b000, playerPressed}, 4'b0001);
        check("press3_num", {2'b00, playerNum}, 4'b0011);
        check("press3_led", led, 4'b1000);
        step(3); btn = 4'b0000; step(10);
        check_int("press3_count", strobeCnt, 1);

        // Simon turn: lamp follows simonPressed, player presses ignored.
        strobeCnt = 0;
        simonTurn = 1'b1; simonNum = 2'b01; simonPressed = 1'b1; #1;
        check("simon_on", led, 4'b0010);
        btn = 4'b0001;
        step(30);
        check("simon_on_held", led, 4'b0010);
        simonPressed = 1'b0; #1;
        check("simon_off", led, 4'b0000);
        step(30);
        simonPressed = 1'b1; #1;
        check("simon_on2", led, 4'b0010);
        simonTurn = 1'b0; simonPressed = 1'b0;
        step(20);
        check_int("simon_ignored", strobeCnt, 0);
        check("simon_lock_led", led, 4'b0000);
        btn = 4'b0000; step(10);
        check_int("simon_release", strobeCnt, 0);
        check("simon_num", {2'b00, playerNum}, 4'b0011);

        // Simon turn rising while HELD overrides the lamp immediately.
        btn = 4'b0100; step(7);
        check("held_strobe", {3'b000, playerPressed}, 4'b0001);
        simonTurn = 1'b1; simonNum = 2'b00; simonPressed = 1'b1; #1;
        check("held_simon_led", led, 4'b0001);
        simonPressed = 1'b0; #1;
        check("held_simon_dark", led, 4'b0000);
        simonTurn = 1'b0; #1;
        check("held_back_led", led, 4'b0100);

        // Reset while HELD, button kept down through release.
        reset = 1'b1; #1;
        check("hrst_led", led, 4'b0000);
        check("hrst_num", {2'b00, playerNum}, 4'b0000);
        check("hrst_strobe", {3'b000, playerPressed}, 4'b0000);
        step(3);
        reset = 1'b0; strobeCnt = 0;
        step(20);
        check_int("hrst_no_strobe", strobeCnt, 0);
        check("hrst_lock_led", led, 4'b0000);
        btn = 4'b0000; step(10);
        check_int("hrst_release", strobeCnt, 0);
        btn = 4'b0100; step(7);
        check("hrst_repress", {3'b000, playerPressed}, 4'b0001);
        check("hrst_num2", {2'b00, playerNum}, 4'b0010);
        btn = 4'b0000; step(10);

        // Game over lamps; presses ignored.
        strobeCnt = 0;
        gameOver = 1'b1; #1;
        check("go_start", led, 4'b1111);
        btn = 4'b0001;
`ifdef SIMON_PANEL_BLINK_EN
        step(14);
        check("go_phase1_end", led, 4'b1111);
        step(1);
        check("go_phase0", led, 4'b0000);
        step(14);
        check("go_phase0_end", led, 4'b0000);
        step(1);
        check("go_phase1_again", led, 4'b1111);
`else
        step(15);
        check("go_steady1", led, 4'b1111);
        step(15);
        check("go_steady2", led, 4'b1111);
`endif
        btn = 4'b0000; step(10);
        check_int("go_no_strobe", strobeCnt, 0);
        gameOver = 1'b0; #1;
        check("go_clear", led, 4'b0000);
        step(2);
        gameOver = 1'b1; #1;
        check("go_restart", led, 4'b1111);
        gameOver = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
